led_sel_sequencer: RTL and testbench
====================================

// Module: led_sel_sequencer
// PURPOSE
//  Upstream select generator for the 4-LED one-hot decoder: produces the 2-bit
//  select {out1,out0} that drives the decoder's {in1,in0}. Debounces two push
//  buttons (step, mode) and advances the select manually per press, or
//  automatically at a prescaled rate, in a chosen direction.
// PARAMETERS
//  DEBOUNCE_CYC  16          consecutive stable cycles before a debounced level changes (>=2)
//  TICK_DIV      50_000_000  clk cycles per auto-advance step (>=2)
// PORTS
//  clk         in   1  system clock, all state on rising edge
//  rst         in   1  synchronous reset, active-high
//  btn_step    in   1  raw step button, async, active-high
//  btn_mode    in   1  raw mode button, async, active-high
//  dir         in   1  1 = count up, 0 = count down; sampled when an advance occurs
//  out0        out  1  select bit 0, feeds decoder in0
//  out1        out  1  select bit 1, feeds decoder in1
//  auto_on     out  1  1 while FSM is in AUTO
//  step_pulse  out  1  one-cycle strobe on every select advance
// BEHAVIOUR
//  Reset (rst=1 at edge): {out1,out0}=2'b00, auto_on=0, step_pulse=0, FSM=MANUAL,
//   synchronisers/debounced levels=0, debounce counters=0, prescaler=0.
//   rst mid-operation overrides everything in the same edge; no pending press survives.
//  Input path per button: 2-flop synchroniser -> debouncer -> rising-edge detect.
//   Debouncer: counter increments each cycle synced!=debounced, clears when equal;
//   debounced takes synced value when counter reaches DEBOUNCE_CYC-1 while still differing.
//   Press pulse (1 cycle) = debounced rising edge. Release produces no pulse.
//  FSM states: MANUAL, AUTO.
//   MANUAL: mode pulse -> AUTO (prescaler cleared). step pulse -> advance.
//   AUTO: prescaler counts 0..TICK_DIV-1 and wraps; advance on cycle count==TICK_DIV-1.
//     mode pulse -> MANUAL (prescaler cleared, no advance that cycle). step pulse ignored.
//  Advance: sel <= dir ? sel+1 : sel-1, modulo 4 (3->0 up, 0->3 down).
//   sel and step_pulse update on the same edge; step_pulse high exactly one cycle.
//  Latency: step press pulse in cycle N -> new sel and step_pulse visible after edge N+1.
//  Simultaneous events: mode pulse and step pulse same cycle -> mode toggle wins, step dropped.
//   Mode pulse coinciding with AUTO terminal count -> toggle wins, no advance.
//  auto_on is registered and equals (FSM==AUTO).
//  {out1,out0} always one of 00/01/10/11; no X after reset.
// CONFIGURATION
//  LED_SEL_PAUSE_EN defined: in AUTO, step pulse toggles an internal pause flag;
//   while paused, prescaler holds value and no advances occur. Pause clears on reset
//   and on leaving AUTO. Mode+step same cycle: mode wins, pause unchanged.
//  Not defined: step pulse in AUTO ignored (as above); no pause flag exists.
// TESTING  (bench params DEBOUNCE_CYC=4, TICK_DIV=8)
//  1 rst 3 cycles -> out=00, auto_on=0, step_pulse=0; hold 20 cycles, no change.
//  2 MANUAL dir=1: 5 clean presses -> sel 01,10,11,00,01; one step_pulse per press;
//    dir=0 from 00 -> 11 (wrap down).
//  3 Bounce: btn_step toggles every 2 cycles for 12 cycles then steady high
//    -> exactly one advance, no step_pulse during bounce.
//  4 Press mode -> auto_on=1; with dir=1 sel advances every 8 cycles from entry
//    (00->01->10->11->00); btn_step presses change nothing (pause macro off).
//  5 Mode and step pulses forced same cycle in MANUAL -> auto_on=1, sel unchanged.
//  6 rst asserted in AUTO mid-prescale, sel=10 -> next edge out=00, auto_on=0,
//    no step_pulse; with LED_SEL_PAUSE_EN: step in AUTO freezes sel >=16 cycles,
//    second step resumes with next advance 8 cycles later.

Source files
------------

// File: rtl/led_sel_sequencer.sv
// LED select sequencer: debounced step/mode buttons advance a 2-bit decoder select, manually or on a prescaled tick.
// Optional build macro LED_SEL_PAUSE_EN: a step press while in AUTO toggles a pause of the auto prescaler.
//
// state  | meaning
// MANUAL | select advances once per debounced step press
// AUTO   | select advances every TICK_DIV cycles; step press ignored (or toggles pause)
module led_sel_sequencer #(
  parameter int DEBOUNCE_CYC = 16,
  parameter int TICK_DIV     = 50_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_step,
  input  logic btn_mode,
  input  logic dir,
  output logic out0,
  output logic out1,
  output logic auto_on,
  output logic step_pulse
);

  localparam int DW = $clog2(DEBOUNCE_CYC);
  localparam int PW = $clog2(TICK_DIV);
  localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYC - 1);
  localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

  typedef enum logic {MANUAL = 1'b0, AUTO = 1'b1} state_e;

  // Index 0 = step button, index 1 = mode button.
  logic [1:0]    s1_q, s2_q, db_q, db_dly_q;
  logic [DW-1:0] cnt_q [2];
  logic [1:0]    press;
  logic          step_p, mode_p;

  state_e        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [PW-1:0] presc_q, presc_d;
  logic          step_pulse_q, auto_on_q;
  logic          adv, run;
`ifdef LED_SEL_PAUSE_EN
  logic          pause_q, pause_d;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q     <= '0;
      s2_q     <= '0;
      db_q     <= '0;
      db_dly_q <= '0;
      cnt_q[0] <= '0;
      cnt_q[1] <= '0;
    end else begin
      s1_q     <= {btn_mode, btn_step};
      s2_q     <= s1_q;
      db_dly_q <= db_q;
      for (int i = 0; i < 2; i++) begin
        if (s2_q[i] != db_q[i]) begin
          if (cnt_q[i] == DB_LAST) begin
            db_q[i]  <= s2_q[i];
            cnt_q[i] <= '0;
          end else begin
            cnt_q[i] <= cnt_q[i] + DW'(1);
          end
        end else begin
          cnt_q[i] <= '0;
        end
      end
    end
  end

  assign press  = db_q & ~db_dly_q;
  assign step_p = press[0];
  assign mode_p = press[1];

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    presc_d = presc_q;
    adv     = 1'b0;
    run     = 1'b1;
`ifdef LED_SEL_PAUSE_EN
    pause_d = pause_q;
    run     = !pause_q;
`endif
    case (state_q)
      MANUAL: begin
        if (mode_p) begin
          state_d = AUTO;
          presc_d = '0;
        end else if (step_p) begin
          adv = 1'b1;
        end
      end
      AUTO: begin
        // A mode press wins over both a step press and a terminal count.
        if (mode_p) begin
          state_d = MANUAL;
          presc_d = '0;
`ifdef LED_SEL_PAUSE_EN
          pause_d = 1'b0;
`endif
        end else begin
`ifdef LED_SEL_PAUSE_EN
          if (step_p) pause_d = !pause_q;
`endif
          if (run) begin
            if (presc_q == TICK_LAST) begin
              presc_d = '0;
              adv     = 1'b1;
            end else begin
              presc_d = presc_q + PW'(1);
            end
          end
        end
      end
      default: state_d = MANUAL;
    endcase
    if (adv) sel_d = dir ? sel_q + 2'd1 : sel_q - 2'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= MANUAL;
      sel_q        <= 2'b00;
      presc_q      <= '0;
      step_pulse_q <= 1'b0;
      auto_on_q    <= 1'b0;
`ifdef LED_SEL_PAUSE_EN
      pause_q      <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      presc_q      <= presc_d;
      step_pulse_q <= adv;
      auto_on_q    <= (state_d == AUTO);
`ifdef LED_SEL_PAUSE_EN
      pause_q      <= pause_d;
`endif
    end
  end

  assign out0       = sel_q[0];
  assign out1       = sel_q[1];
  assign auto_on    = auto_on_q;
  assign step_pulse = step_pulse_q;

endmodule

// File: tb/tb_led_sel_sequencer.sv
// Bench for led_sel_sequencer: scenario tasks plus randomized buttons, checked against a history-based reference model.
module tb_led_sel_sequencer;

  localparam int DB = 4;
  localparam int TD = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic btn_step = 1'b0;
  logic btn_mode = 1'b0;
  logic dir = 1'b1;
  logic out0, out1, auto_on, step_pulse;

  int vec = 0;
  int err = 0;

  led_sel_sequencer #(.DEBOUNCE_CYC(DB), .TICK_DIV(TD)) dut (
    .clk(clk), .rst(rst), .btn_step(btn_step), .btn_mode(btn_mode), .dir(dir),
    .out0(out0), .out1(out1), .auto_on(auto_on), .step_pulse(step_pulse)
  );

  always #5 clk = ~clk;

  // Reference model. rec[b][k] is the raw level captured at edge k; the
  // synchronised level seen at edge k is rec[b][k-2]. A debounced level flips
  // once DB consecutive edges since its last flip all saw the opposite level.
  int         e = 0;
  logic       rec [2][16];
  logic       db_m [2];
  int         last_flip [2];
  logic       pend [2];
  logic [1:0] sel_m = 2'b00;
  logic       auto_m = 1'b0;
  logic       pulse_m = 1'b0;
  logic       paused_m = 1'b0;
  int         acnt = 0;
  logic       sp, mp, adv_m, stable;

  always @(posedge clk) begin
    e = e + 1;
    if (rst) begin
      for (int b = 0; b < 2; b++) begin
        rec[b][e & 15]       = 1'b0;
        rec[b][(e - 1) & 15] = 1'b0;
        db_m[b]      = 1'b0;
        last_flip[b] = e;
        pend[b]      = 1'b0;
      end
      sel_m = 2'b00; auto_m = 1'b0; pulse_m = 1'b0; paused_m = 1'b0; acnt = 0;
    end else begin
      sp = pend[0];
      mp = pend[1];
      adv_m = 1'b0;
      if (mp) begin
        auto_m = !auto_m;
        acnt = 0;
        paused_m = 1'b0;
      end else if (!auto_m) begin
        adv_m = sp;
      end else begin
        if (!paused_m) begin
          acnt = acnt + 1;
          adv_m = (acnt % TD == 0);
        end
`ifdef LED_SEL_PAUSE_EN
        if (sp) paused_m = !paused_m;
`endif
      end
      if (adv_m) sel_m = dir ? sel_m + 2'd1 : sel_m - 2'd1;
      pulse_m = adv_m;
      for (int b = 0; b < 2; b++) begin
        stable = (e - DB + 1 > last_flip[b]);
        for (int j = 0; j < DB; j++)
          if (rec[b][(e - 2 - j) & 15] == db_m[b]) stable = 1'b0;
        pend[b] = 1'b0;
        if (stable) begin
          db_m[b] = !db_m[b];
          last_flip[b] = e;
          pend[b] = db_m[b];
        end
        rec[b][e & 15] = (b == 0) ? btn_step : btn_mode;
      end
    end
  end

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      vec++;
      if ({out1, out0} !== 2'b00 || auto_on !== 1'b0 || step_pulse !== 1'b0) begin
        err++;
        $display("FAIL reset_hold dut sel=%0d auto=%0b pulse=%0b need 0/0/0", {out1, out0}, auto_on, step_pulse);
      end
    end
    rst = 1'b0;
    repeat (20) begin
      @(negedge clk);
      vec++;
      if ({out1, out0} !== 2'b00 || auto_on !== 1'b0 || step_pulse !== 1'b0) begin
        err++;
        $display("FAIL reset_idle dut sel=%0d auto=%0b pulse=%0b need 0/0/0", {out1, out0}, auto_on, step_pulse);
      end
    end
  endtask

  task automatic test_manual();
    logic [1:0] exp_sel [7] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd0, 2'd3};
    int pulses;
    for (int p = 0; p < 7; p++) begin
      dir = (p < 5);
      pulses = 0;
      for (int ph = 0; ph < 2; ph++) begin
        btn_step = (ph == 0);
        repeat (10) begin
          @(negedge clk);
          vec++;
          if ({out1, out0} !== sel_m || auto_on !== auto_m || step_pulse !== pulse_m) begin
            err++;
            $display("FAIL manual_cycle dut=%0d/%0b/%0b model=%0d/%0b/%0b", {out1, out0}, auto_on, step_pulse, sel_m, auto_m, pulse_m);
          end
          if (step_pulse) pulses++;
        end
      end
      vec++;
      if ({out1, out0} !== exp_sel[p] || pulses != 1) begin
        err++;
        $display("FAIL manual_press%0d sel=%0d pulses=%0d need sel=%0d pulses=1", p, {out1, out0}, pulses, exp_sel[p]);
      end
    end
  endtask

  task automatic test_bounce();
    int pulses = 0;
    logic [1:0] start = sel_m;
    dir = 1'b1;
    for (int c = 0; c < 36; c++) begin
      btn_step = (c < 12) ? ((c / 2) % 2 == 0) : (c < 24);
      @(negedge clk);
      vec++;
      if ({out1, out0} !== sel_m || auto_on !== auto_m || step_pulse !== pulse_m) begin
        err++;
        $display("FAIL bounce_cycle dut=%0d/%0b/%0b model=%0d/%0b/%0b", {out1, out0}, auto_on, step_pulse, sel_m, auto_m, pulse_m);
      end
      if (step_pulse) begin
        pulses++;
        if (c < 12) begin
          err++;
          $display("FAIL bounce_early pulse at cycle %0d need none during bounce", c);
        end
      end
    end
    vec++;
    if (pulses != 1 || {out1, out0} !== start + 2'd1) begin
      err++;
      $display("FAIL bounce_total pulses=%0d sel=%0d need pulses=1 sel=%0d", pulses, {out1, out0}, start + 2'd1);
    end
  endtask

  task automatic test_auto();
    int pulses = 0;
    int last = -1;
    logic [1:0] start;
    dir = 1'b1;
    for (int c = 0; c < 20; c++) begin
      btn_mode = (c < 10);
      @(negedge clk);
      vec++;
      if ({out1, out0} !== sel_m || auto_on !== auto_m || step_pulse !== pulse_m) begin
        err++;
        $display("FAIL auto_entry dut=%0d/%0b/%0b model=%0d/%0b/%0b", {out1, out0}, auto_on, step_pulse, sel_m, auto_m, pulse_m);
      end
    end
    vec++;
    if (auto_on !== 1'b1) begin
      err++;
      $display("FAIL auto_on dut=%0b need 1", auto_on);
    end
    start = sel_m;
    for (int c = 0; c < 64; c++) begin
`ifndef LED_SEL_PAUSE_EN
      if (c % 8 == 0) btn_step = 1'($urandom_range(0, 1));
`endif
      @(negedge clk);
      vec++;
      if ({out1, out0} !== sel_m || auto_on !== auto_m || step_pulse !== pulse_m) begin
        err++;
        $display("FAIL auto_cycle dut=%0d/%0b/%0b model=%0d/%0b/%0b", {out1, out0}, auto_on, step_pulse, sel_m, auto_m, pulse_m);
      end
      if (step_pulse) begin
        pulses++;
        vec++;
        if ((last >= 0 && c - last != TD) || {out1, out0} !== start + 2'(pulses)) begin
          err++;
          $display("FAIL auto_step gap=%0d sel=%0d need gap=%0d sel=%0d", c - last, {out1, out0}, TD, start + 2'(pulses));
        end
        last = c;
      end
    end
    btn_step = 1'b0;
    vec++;
    if (pulses != 64 / TD) begin
      err++;
      $display("FAIL auto_count pulses=%0d need %0d", pulses, 64 / TD);
    end
  endtask

  task automatic test_mode_step_same();
    int pulses = 0;
    logic [1:0] base;
    for (int c = 0; c < 20; c++) begin
      btn_mode = (c < 10);
      @(negedge clk);
      vec++;
      if ({out1, out0} !== sel_m || auto_on !== auto_m || step_pulse !== pulse_m) begin
        err++;
        $display("FAIL same_exit dut=%0d/%0b/%0b model=%0d/%0b/%0b", {out1, out0}, auto_on, step_pulse, sel_m, auto_m, pulse_m);
      end
    end
    vec++;
    if (auto_on !== 1'b0) begin
      err++;
      $display("FAIL same_manual auto=%0b need 0", auto_on);
    end
    base = sel_m;
    btn_mode = 1'b1;
    btn_step = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (step_pulse) pulses++;
    end
    vec++;
    if (auto_on !== 1'b1 || {out1, out0} !== base || pulses != 0) begin
      err++;
      $display("FAIL same_cycle auto=%0b sel=%0d pulses=%0d need auto=1 sel=%0d pulses=0", auto_on, {out1, out0}, pulses, base);
    end
    btn_mode = 1'b0;
    btn_step = 1'b0;
    repeat (10) begin
      @(negedge clk);
      vec++;
      if ({out1, out0} !== sel_m || auto_on !== auto_m || step_pulse !== pulse_m) begin
        err++;
        $display("FAIL same_release dut=%0d/%0b/%0b model=%0d/%0b/%0b", {out1, out0}, auto_on, step_pulse, sel_m, auto_m, pulse_m);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic found = 1'b0;
    dir = 1'b1;
    for (int c = 0; c < 80 && !found; c++) begin
      @(negedge clk);
      if (auto_m && pulse_m && sel_m == 2'd2) found = 1'b1;
    end
    vec++;
    if (!found) begin
      err++;
      $display("FAIL reset_mid_wait sel never reached 2 in AUTO within 80 cycles");
    end
    repeat (3) @(negedge clk);
    vec++;
    if ({out1, out0} !== 2'd2 || auto_on !== 1'b1) begin
      err++;
      $display("FAIL reset_mid_pre sel=%0d auto=%0b need sel=2 auto=1", {out1, out0}, auto_on);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    vec++;
    if ({out1, out0} !== 2'b00 || auto_on !== 1'b0 || step_pulse !== 1'b0) begin
      err++;
      $display("FAIL reset_mid sel=%0d auto=%0b pulse=%0b need 0/0/0", {out1, out0}, auto_on, step_pulse);
    end
  endtask

  task automatic test_random();
    int len;
    for (int s = 0; s < 300; s++) begin
      btn_step = 1'($urandom_range(0, 1));
      btn_mode = ($urandom_range(0, 3) == 0);
      dir      = 1'($urandom_range(0, 1));
      len      = $urandom_range(1, 14);
      for (int c = 0; c < len; c++) begin
        rst = ($urandom_range(0, 199) == 0);
        @(negedge clk);
        vec++;
        if ({out1, out0} !== sel_m || auto_on !== auto_m || step_pulse !== pulse_m) begin
          err++;
          $display("FAIL random_cycle t=%0t dut=%0d/%0b/%0b model=%0d/%0b/%0b", $time, {out1, out0}, auto_on, step_pulse, sel_m, auto_m, pulse_m);
        end
      end
    end
    rst = 1'b0;
  endtask

  initial begin
    test_reset();
    test_manual();
    test_bounce();
    test_auto();
    test_mode_step_same();
    test_reset_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
